// File: rtl/seg7_pkg.sv
// Shared definitions for 7-segment display blocks: segment bit positions,
// active-high glyph patterns and the frame record held by the scan controller.
package seg7_pkg;

  localparam int MAX_DIGITS = 16;
  localparam int CNT_W      = 5;

  // Segment bit positions on the 8-bit segment bus
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high glyphs, bit0 = segment a ... bit6 = segment g
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // One displayable frame, sized for the largest supported digit count
  typedef struct packed {
    logic [4*MAX_DIGITS-1:0] data;
    logic [CNT_W-1:0]        cnt;
    logic [MAX_DIGITS-1:0]   dp;
    logic [MAX_DIGITS-1:0]   blink;
    logic                    hex_en;
  } frame_t;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-high 7-segment glyph; codes 10-15 render as letters only
// when hex_en is set, otherwise they are blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] glyph
);

  // Glyph lookup
  always_comb begin
    glyph = GLYPH_BLANK;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = hex_en ? GLYPH_A : GLYPH_BLANK;
      4'hB: glyph = hex_en ? GLYPH_B : GLYPH_BLANK;
      4'hC: glyph = hex_en ? GLYPH_C : GLYPH_BLANK;
      4'hD: glyph = hex_en ? GLYPH_D : GLYPH_BLANK;
      4'hE: glyph = hex_en ? GLYPH_E : GLYPH_BLANK;
      4'hF: glyph = hex_en ? GLYPH_F : GLYPH_BLANK;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scanner. Frames arrive over a
// valid/ready handshake into a pending register and are promoted to the
// active register only at a frame boundary, so a frame never tears.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV_W   = 17,
  parameter int BLINK_DIV_W  = 24,
  parameter bit SEG_ACT_HIGH = 1'b1,
  parameter bit SEL_ACT_LOW  = 1'b1,
  localparam int CW = $clog2(N_DIGITS + 1),
  localparam int IW = $clog2(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*N_DIGITS-1:0] frame_data,
  input  logic [CW-1:0]         frame_cnt,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  hex_en,
  output logic [7:0]            seg_data,
  output logic [N_DIGITS-1:0]   seg_sel,
  output logic                  frame_start
);

  logic [SCAN_DIV_W-1:0]  dwell;
  logic [BLINK_DIV_W-1:0] blink_cnt;
  logic [IW-1:0]          idx;
  logic                   pend;
  logic                   dwell_tc;
  logic                   boundary;
  frame_t                 offered;
  frame_t                 pending;
  frame_t                 active;
  logic [3:0]             nibble;
  logic                   dig_shown;
  logic                   dig_dp;
  logic                   dig_blink;
  logic [6:0]             glyph;
  logic [7:0]             seg_on;
  logic [N_DIGITS-1:0]    sel_on;

  assign dwell_tc   = &dwell;
  assign boundary   = dwell_tc && (idx == IW'(N_DIGITS - 1));
  assign load_ready = !pend;

  // Dwell, blink and digit-index counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell     <= '0;
      blink_cnt <= '0;
      idx       <= '0;
    end else begin
      dwell     <= dwell + SCAN_DIV_W'(1);
      blink_cnt <= blink_cnt + BLINK_DIV_W'(1);
      if (dwell_tc) idx <= boundary ? '0 : idx + IW'(1);
    end
  end

  // Pack the offered frame, saturating the digit count at N_DIGITS
  always_comb begin
    offered                        = '0;
    offered.data[4*N_DIGITS-1:0]   = frame_data;
    offered.cnt                    = (int'(frame_cnt) > N_DIGITS) ? CNT_W'(N_DIGITS)
                                                                  : CNT_W'(frame_cnt);
    offered.dp[N_DIGITS-1:0]       = dp_mask;
    offered.blink[N_DIGITS-1:0]    = blink_mask;
    offered.hex_en                 = hex_en;
  end

  // Handshake and shadow registers; promotion wins over capture because a
  // pending frame holds load_ready low, so both can never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      pending <= '0;
      active  <= '0;
    end else if (pend && boundary) begin
      active <= pending;
      pend   <= 1'b0;
    end else if (load_valid && !pend) begin
      pending <= offered;
      pend    <= 1'b1;
    end
  end

  // Pick the active digit's nibble and per-digit flags
  always_comb begin
    nibble    = '0;
    dig_shown = 1'b0;
    dig_dp    = 1'b0;
    dig_blink = 1'b0;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (k < N_DIGITS && idx == IW'(k)) begin
        nibble    = active.data[4*k +: 4];
        dig_shown = int'(active.cnt) > k;
        dig_dp    = active.dp[k];
        dig_blink = active.blink[k];
      end
    end
  end

  seg7_decode u_decode (
    .nibble (nibble),
    .hex_en (active.hex_en),
    .glyph  (glyph)
  );

  // Logical (active-high) segment and select values for the current digit
  always_comb begin
    seg_on = '0;
    if (dig_shown) seg_on[SEG_G:SEG_A] = glyph;
    seg_on[SEG_DP] = dig_dp;
    if (dig_blink && blink_cnt[BLINK_DIV_W-1]) seg_on = '0;
    sel_on      = '0;
    sel_on[idx] = 1'b1;
  end

  // Registered pin drivers with polarity applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_data    <= SEG_ACT_HIGH ? 8'h00 : 8'hFF;
      seg_sel     <= {N_DIGITS{SEL_ACT_LOW}};
      frame_start <= 1'b0;
    end else begin
      seg_data    <= SEG_ACT_HIGH ? seg_on : ~seg_on;
      seg_sel     <= SEL_ACT_LOW ? ~sel_on : sel_on;
      frame_start <= (idx == '0) && (dwell == '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (4 digits, 4-cycle dwell, 32-cycle blink).
// The reference model works from the cycle count since reset release and a
// list of accepted frames; the monitor compares every cycle.
module tb_seg7_scan_ctrl;

  localparam int N      = 4;
  localparam int DWELL  = 4;
  localparam int FRAME  = N * DWELL;
  localparam int BHALF  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] frame_data = '0;
  logic [2:0]  frame_cnt = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic        hex_en = 1'b0;
  logic [7:0]  seg_data;
  logic [3:0]  seg_sel;
  logic        frame_start;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .N_DIGITS(N), .SCAN_DIV_W(2), .BLINK_DIV_W(5),
    .SEG_ACT_HIGH(1'b1), .SEL_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .frame_data(frame_data), .frame_cnt(frame_cnt), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .hex_en(hex_en), .seg_data(seg_data),
    .seg_sel(seg_sel), .frame_start(frame_start)
  );

  typedef struct {
    logic [15:0] d;
    int          c;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic        hx;
  } mframe_t;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] sel;
    logic       fs;
    logic       rdy;
  } exp_t;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  exp_t    sb[$];
  mframe_t act, pnd;
  bit      pend;
  int      k;
  int      acc_count;
  int      compared;
  int      mismatched;

  function automatic mframe_t blank_frame();
    mframe_t f;
    f.d = '0; f.c = 0; f.dp = '0; f.bl = '0; f.hx = 1'b0;
    return f;
  endfunction

  function automatic logic [7:0] model_seg(mframe_t f, int digit, bit blink_phase);
    logic [7:0] s;
    int v;
    s = 8'h00;
    v = int'((f.d >> (4 * digit)) & 16'hF);
    if (digit < f.c && (v < 10 || f.hx)) s[6:0] = glyph_tab[v];
    s[7] = f.dp[digit];
    if (blink_phase && f.bl[digit]) s = 8'h00;
    return s;
  endfunction

  // Reference model: expected pins for cycle n = k-1 after release, then
  // apply boundary promotion (every FRAME-th edge) or frame capture
  always @(posedge clk) begin
    if (!rst_n) begin
      k    = 0;
      pend = 1'b0;
      act  = blank_frame();
      pnd  = blank_frame();
    end else begin
      int   n;
      int   digit;
      exp_t e;
      k++;
      n     = k - 1;
      digit = (n / DWELL) % N;
      e.seg = model_seg(act, digit, ((n / BHALF) % 2) == 1);
      e.sel = ~(4'b0001 << digit);
      e.fs  = (n % FRAME) == 0;
      if (pend && (k % FRAME) == 0) begin
        act  = pnd;
        pend = 1'b0;
      end else if (load_valid && !pend) begin
        pnd.d  = frame_data;
        pnd.c  = (int'(frame_cnt) > N) ? N : int'(frame_cnt);
        pnd.dp = dp_mask;
        pnd.bl = blink_mask;
        pnd.hx = hex_en;
        pend   = 1'b1;
        acc_count++;
      end
      e.rdy = !pend;
      sb.push_back(e);
    end
  end

  // Monitor: pins are valid every cycle once running
  always @(negedge clk) begin
    if (rst_n && k > 0) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL scoreboard_underflow t=%0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        compared++;
        if (seg_data !== e.seg || seg_sel !== e.sel || frame_start !== e.fs || load_ready !== e.rdy) begin
          mismatched++;
          $display("FAIL scan t=%0t got seg=%h sel=%b fs=%b rdy=%b want seg=%h sel=%b fs=%b rdy=%b",
                   $time, seg_data, seg_sel, frame_start, load_ready, e.seg, e.sel, e.fs, e.rdy);
        end
      end
    end
  end

  task automatic check_reset_pins(input string tag);
    compared++;
    if (seg_data !== 8'h00 || seg_sel !== 4'hF || frame_start !== 1'b0 || load_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s got seg=%h sel=%b fs=%b rdy=%b want seg=00 sel=1111 fs=0 rdy=1",
               tag, seg_data, seg_sel, frame_start, load_ready);
    end
  endtask

  // Offer one frame and hold it until the model records acceptance
  task automatic send(input logic [15:0] d, input logic [2:0] c, input logic [3:0] dp,
                      input logic [3:0] bl, input logic hx);
    int n0;
    int t;
    frame_data = d; frame_cnt = c; dp_mask = dp; blink_mask = bl; hex_en = hx;
    load_valid = 1'b1;
    n0 = acc_count;
    t  = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (acc_count == n0 && t < 100);
    load_valid = 1'b0;
    compared++;
    if (acc_count == n0) begin
      mismatched++;
      $display("FAIL load_accept got no transfer in %0d cycles want transfer", t);
    end
  endtask

  task automatic wait_phase(input int ph);
    int t;
    t = 0;
    while ((pend || (k % FRAME) != ph) && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    acc_count  = 0;
    k          = 0;
    #1 rst_n = 1'b0;
    #1 check_reset_pins("reset_initial");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle frames: all blank, select rotates
    repeat (40) @(negedge clk);

    // Decimal digits, partial count
    send(16'h3210, 3'd3, 4'b0000, 4'b0000, 1'b0);
    repeat (40) @(negedge clk);

    // Hex on/off and a decimal point on digit 3
    send(16'h00FA, 3'd4, 4'b0000, 4'b0000, 1'b1);
    repeat (36) @(negedge clk);
    send(16'h00FA, 3'd4, 4'b0000, 4'b0000, 1'b0);
    repeat (36) @(negedge clk);
    send(16'h00FA, 3'd4, 4'b1000, 4'b0000, 1'b1);
    repeat (36) @(negedge clk);

    // Back-to-back loads, second with an oversized count
    send(16'h1234, 3'd4, 4'b0101, 4'b0000, 1'b0);
    send(16'h5678, 3'd7, 4'b0010, 4'b0000, 1'b1);
    repeat (40) @(negedge clk);

    // Transfer landing exactly in the boundary cycle
    wait_phase(FRAME - 1);
    send(16'hABCD, 3'd4, 4'b0000, 4'b0000, 1'b1);
    repeat (40) @(negedge clk);

    // Blink on digit 0 across more than two blink periods
    send(16'h9876, 3'd4, 4'b0001, 4'b0001, 1'b0);
    repeat (80) @(negedge clk);

    // Randomised frames with random gaps
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send(16'($urandom), 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom));
    end
    repeat (40) @(negedge clk);

    // Reset mid-frame while a frame is pending
    wait_phase(2);
    send(16'h8888, 3'd4, 4'b1111, 4'b0000, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    sb.delete();
    #1 check_reset_pins("reset_async_midframe");
    repeat (3) @(posedge clk);
    #1 check_reset_pins("reset_held");
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (50) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
